clk_div_checker: RTL and testbench

- Downstream monitor for the ripple/counter clock divider outputs (clkdiv2, clkdiv4, clkdiv8, clkdiv16), clocked by the same `clk`.
- Samples each divided clock as synchronous data and detects its rising edges.
- Measures each channel's period in `clk` cycles and checks it against the expected 2^(i+1).
- Reports per-channel lock and sticky fault status; used as a self-check / bring-up monitor beside the divider.

---
 rtl/clk_div_checker.sv | 114 +++++++++++
 tb/tb_clk_div_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_checker.sv
// clk_div_checker: monitors divided clocks on clk, measures each period, reports lock and sticky faults
// Ports: clk, rst_n (async active-low), enable, clear (sync pulse), clkdiv_in[NUM_CH] (bit0=clkdiv2),
//   locked[NUM_CH], err[NUM_CH] (sticky), all_locked, period_out[NUM_CH*CNT_W] (ch i at [i*CNT_W +: CNT_W]).
// Optional macro CLK_DIV_CHK_IRQ_EN adds irq: one-cycle pulse on any err rise or locked fall.
module clk_div_checker #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       clkdiv_in,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       err,
  output logic                    all_locked,
  output logic [NUM_CH*CNT_W-1:0] period_out
`ifdef CLK_DIV_CHK_IRQ_EN
  ,
  output logic                    irq
`endif
);
  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, LOCKED, FAULT} state_t;
  state_t st [NUM_CH];
  state_t st_n [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] cnt_n [NUM_CH];
  logic [3:0] good [NUM_CH];
  logic [3:0] good_n [NUM_CH];
  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] edg;
  logic [NUM_CH-1:0] err_n;
  logic [NUM_CH*CNT_W-1:0] per_n;
`ifdef CLK_DIV_CHK_IRQ_EN
  logic [NUM_CH-1:0] locked_n;
`endif
  // inputs already live in the clk domain, so a single sample register suffices
  assign edg = clkdiv_in & ~s;
  always_comb begin
    err_n = err;
    per_n = period_out;
    for (int i = 0; i < NUM_CH; i++) begin
      st_n[i] = st[i];
      good_n[i] = good[i];
      cnt_n[i] = edg[i] ? CNT_W'(1) : cnt[i] + CNT_W'(cnt[i] != '1);
      locked[i] = st[i] == LOCKED;
      if (clear || !enable) begin
        st_n[i] = WAIT_EDGE;
        cnt_n[i] = '0;
        good_n[i] = '0;
        err_n[i] = err[i] & ~clear;
      end else if (!edg[i]) begin
        if (cnt[i] == CNT_W'(TIMEOUT) && st[i] != FAULT) begin
          st_n[i] = FAULT;
          err_n[i] = 1'b1;
        end
      end else begin
        // the first edge of a run only starts the count, it carries no period
        if (st[i] != WAIT_EDGE) per_n[i*CNT_W +: CNT_W] = cnt[i];
        case (st[i])
          WAIT_EDGE: begin
            st_n[i] = MEASURE;
            good_n[i] = '0;
          end
          MEASURE: begin
            good_n[i] = cnt[i] == CNT_W'(2 ** (i + 1)) ? good[i] + 4'd1 : 4'd0;
            st_n[i] = good_n[i] == 4'(LOCK_CNT) ? LOCKED : MEASURE;
          end
          LOCKED: begin
            if (cnt[i] != CNT_W'(2 ** (i + 1))) begin
              st_n[i] = FAULT;
              err_n[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
`ifdef CLK_DIV_CHK_IRQ_EN
      locked_n[i] = st_n[i] == LOCKED;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      err <= '0;
      period_out <= '0;
      all_locked <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= WAIT_EDGE;
        cnt[i] <= '0;
        good[i] <= '0;
      end
    end else begin
      s <= clkdiv_in;
      err <= err_n;
      period_out <= per_n;
      all_locked <= &locked;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= st_n[i];
        cnt[i] <= cnt_n[i];
        good[i] <= good_n[i];
      end
    end
  end
`ifdef CLK_DIV_CHK_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else irq <= |((err_n & ~err) | (locked & ~locked_n));
  end
`endif
endmodule

// File: tb/tb_clk_div_checker.sv
// tb_clk_div_checker: directed self-checking bench for clk_div_checker
module tb_clk_div_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic [3:0] clkdiv_in = '0;
  logic [3:0] locked;
  logic [3:0] err;
  logic all_locked;
  logic [31:0] period_out;
`ifdef CLK_DIV_CHK_IRQ_EN
  logic irq;
  int irq_pulses;
`endif
  int cmps, fails, t;
  int p [4];
  int ph [4];
  int last [4];
  logic [3:0] hold, rose;

  always #5 clk = ~clk;

  clk_div_checker dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .clkdiv_in(clkdiv_in),
    .locked(locked), .err(err), .all_locked(all_locked), .period_out(period_out)
`ifdef CLK_DIV_CHK_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic model_init();
    p = '{2, 4, 8, 16};
    for (int i = 0; i < 4; i++) begin
      ph[i] = p[i] - 1;
      last[i] = 0;
    end
    hold = '0;
    rose = '0;
    t = 0;
  endtask

  // one clk cycle: the posedge consumes the previous drive, then the next divider values are driven
  task automatic tick();
    logic [3:0] v;
    @(posedge clk);
    #1;
    t++;
    for (int i = 0; i < 4; i++) begin
      ph[i] = (ph[i] + 1) % p[i];
      v[i] = hold[i] ? 1'b0 : (ph[i] < (p[i] + 1) / 2);
    end
    rose = v & ~clkdiv_in;
    for (int i = 0; i < 4; i++) if (rose[i]) last[i] = t;
    clkdiv_in = v;
`ifdef CLK_DIV_CHK_IRQ_EN
    irq_pulses += int'(irq);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    clkdiv_in = '0;
    model_init();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cmps++; if (locked !== 4'h0) begin fails++; $display("FAIL reset_locked: got %b want 0000", locked); end
    cmps++; if (err !== 4'h0) begin fails++; $display("FAIL reset_err: got %b want 0000", err); end
    cmps++; if (all_locked !== 1'b0) begin fails++; $display("FAIL reset_all_locked: got %b want 0", all_locked); end
    cmps++; if (period_out !== 32'h0) begin fails++; $display("FAIL reset_period: got %h want 0", period_out); end
  endtask

  task automatic test_lock();
    while (t < 67) begin
      tick();
      if (t == 9 || t == 10) begin
        cmps++; if (locked[0] !== (t == 10)) begin fails++; $display("FAIL lock0_t%0d: got %b want %b", t, locked[0], t == 10); end
      end
      if (t == 65 || t == 66) begin
        cmps++; if (locked[3] !== (t == 66)) begin fails++; $display("FAIL lock3_t%0d: got %b want %b", t, locked[3], t == 66); end
      end
      if (t == 66 || t == 67) begin
        cmps++; if (all_locked !== (t == 67)) begin fails++; $display("FAIL all_locked_t%0d: got %b want %b", t, all_locked, t == 67); end
      end
    end
    cmps++; if (period_out !== 32'h10080402) begin fails++; $display("FAIL lock_period: got %h want 10080402", period_out); end
    cmps++; if (err !== 4'h0) begin fails++; $display("FAIL lock_err: got %b want 0000", err); end
    cmps++; if (locked !== 4'hf) begin fails++; $display("FAIL lock_all: got %b want 1111", locked); end
  endtask

  task automatic test_timeout();
    int l;
`ifdef CLK_DIV_CHK_IRQ_EN
    irq_pulses = 0;
`endif
    hold[2] = 1'b1;
    l = last[2];
    while (t < l + 64) tick();
    cmps++; if ({err[2], locked[2]} !== 2'b01) begin fails++; $display("FAIL tmo_before: got err=%b locked=%b want 0 1", err[2], locked[2]); end
    tick();
    cmps++; if (err !== 4'b0100) begin fails++; $display("FAIL tmo_err: got %b want 0100", err); end
    cmps++; if (locked !== 4'b1011) begin fails++; $display("FAIL tmo_locked: got %b want 1011", locked); end
    tick();
`ifdef CLK_DIV_CHK_IRQ_EN
    cmps++; if (irq_pulses !== 1) begin fails++; $display("FAIL tmo_irq: got %0d pulses want 1", irq_pulses); end
`endif
  endtask

  task automatic test_bad_period();
    int bad, s0;
    do_reset();
    p[1] = 6;
    ph[1] = 5;
    bad = 0;
    repeat (80) begin
      tick();
      if (locked[1] !== 1'b0) bad++;
    end
    cmps++; if (bad !== 0) begin fails++; $display("FAIL bad_never_lock: got %0d locked cycles want 0", bad); end
    cmps++; if (period_out[15:8] !== 8'd6) begin fails++; $display("FAIL bad_period: got %0d want 6", period_out[15:8]); end
    cmps++; if (err !== 4'h0) begin fails++; $display("FAIL bad_err: got %b want 0000", err); end
    cmps++; if (locked !== 4'b1101) begin fails++; $display("FAIL bad_others: got %b want 1101", locked); end
    for (int k = 0; k < 10 && ph[1] != 5; k++) tick();
    p[1] = 4;
    ph[1] = 3;
    s0 = t + 1;
    while (t < s0 + 16) tick();
    cmps++; if (locked[1] !== 1'b0) begin fails++; $display("FAIL relock1_early: got %b want 0", locked[1]); end
    tick();
    cmps++; if (locked[1] !== 1'b1) begin fails++; $display("FAIL relock1: got %b want 1", locked[1]); end
    cmps++; if (period_out[15:8] !== 8'd4) begin fails++; $display("FAIL relock1_period: got %0d want 4", period_out[15:8]); end
  endtask

  task automatic test_glitch_clear();
    int c;
    for (int k = 0; k < 4 && ph[0] != 1; k++) tick();
    p[0] = 3;
    c = t;
    repeat (2) tick();
    p[0] = 2;
    cmps++; if (err[0] !== 1'b0) begin fails++; $display("FAIL glitch_pre: got %b want 0", err[0]); end
    tick();
    cmps++; if ({err[0], locked[0]} !== 2'b10) begin fails++; $display("FAIL glitch_fault: got err=%b locked=%b want 1 0", err[0], locked[0]); end
    cmps++; if (period_out[7:0] !== 8'd3) begin fails++; $display("FAIL glitch_period: got %0d want 3", period_out[7:0]); end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cmps++; if (err !== 4'h0) begin fails++; $display("FAIL clear_err: got %b want 0000", err); end
    cmps++; if (period_out[7:0] !== 8'd3) begin fails++; $display("FAIL clear_period_held: got %0d want 3", period_out[7:0]); end
    while (t < c + 14) tick();
    cmps++; if (locked[0] !== 1'b0) begin fails++; $display("FAIL clear_edge_ignored: got %b want 0", locked[0]); end
    tick();
    cmps++; if (locked[0] !== 1'b1) begin fails++; $display("FAIL clear_relock: got %b want 1", locked[0]); end
  endtask

  task automatic test_enable();
    logic [31:0] po;
    int n, nb, bad;
    for (int k = 0; k < 200 && all_locked !== 1'b1; k++) tick();
    cmps++; if (all_locked !== 1'b1) begin fails++; $display("FAIL en_prelock: got %b want 1", all_locked); end
    hold[2] = 1'b1;
    for (int k = 0; k < 100 && err[2] !== 1'b1; k++) tick();
    po = period_out;
    enable = 1'b0;
    tick();
    cmps++; if (locked !== 4'h0) begin fails++; $display("FAIL dis_locked: got %b want 0000", locked); end
    hold[2] = 1'b0;
    repeat (9) tick();
    cmps++; if (err !== 4'b0100) begin fails++; $display("FAIL dis_err_held: got %b want 0100", err); end
    cmps++; if (period_out !== po) begin fails++; $display("FAIL dis_period_held: got %h want %h", period_out, po); end
    cmps++; if ({all_locked, locked} !== 5'b0) begin fails++; $display("FAIL dis_status: got %b %b want 0 0000", all_locked, locked); end
    enable = 1'b1;
    n = int'(rose[0]);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      nb = n;
      tick();
      n += int'(rose[0]);
      if (locked[0] !== (nb >= 5)) bad++;
    end
    cmps++; if (bad !== 0) begin fails++; $display("FAIL en_relock0_timing: got %0d wrong cycles want 0", bad); end
    for (int k = 0; k < 200 && all_locked !== 1'b1; k++) tick();
    cmps++; if (all_locked !== 1'b1) begin fails++; $display("FAIL en_relock_all: got %b want 1", all_locked); end
    cmps++; if (err !== 4'b0100) begin fails++; $display("FAIL en_err_sticky: got %b want 0100", err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (12) tick();
    cmps++; if ({locked[0], period_out[7:0]} !== 9'h102) begin fails++; $display("FAIL ar_pre: got locked0=%b period0=%0d want 1 2", locked[0], period_out[7:0]); end
    #3;
    rst_n = 1'b0;
    #1;
    cmps++; if (period_out !== 32'h0) begin fails++; $display("FAIL ar_period: got %h want 0", period_out); end
    cmps++; if ({all_locked, locked, err} !== 9'h0) begin fails++; $display("FAIL ar_status: got %b %b %b want 0", all_locked, locked, err); end
    do_reset();
    test_lock();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmps = 0;
    fails = 0;
`ifdef CLK_DIV_CHK_IRQ_EN
    irq_pulses = 0;
`endif
    test_reset();
    test_lock();
    test_timeout();
    test_bad_period();
    test_glitch_clear();
    test_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end
endmodule
